// File: rtl/alu_cmd_issue.sv
// Command issue and response capture around an 8-bit ALU.
// Commands queue in a small FIFO; results land in a held, tagged response register.
module alu_cmd_issue #(
    parameter int DEPTH = 4,
    parameter int OPW   = 8,
    parameter int RESW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_opcode,
    input  logic [OPW-1:0]           cmd_a,
    input  logic [OPW-1:0]           cmd_b,
    output logic [3:0]               alu_opcode,
    output logic [OPW-1:0]           alu_operand1,
    output logic [OPW-1:0]           alu_operand2,
    input  logic [RESW-1:0]          alu_result,
    input  logic                     alu_flagC,
    input  logic                     alu_flagZ,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RESW-1:0]          rsp_result,
    output logic                     rsp_c,
    output logic                     rsp_z,
    output logic [3:0]               rsp_tag,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        RSP_EMPTY,
        RSP_FULL
    } state_t;

    state_t         state;
    state_t         next_state;

    logic [3:0]     op_mem [DEPTH];
    logic [OPW-1:0] a_mem  [DEPTH];
    logic [OPW-1:0] b_mem  [DEPTH];

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [3:0]     issue_tag;

    logic           push;
    logic           pop;
    logic           empty;

    assign empty      = (count == '0);
    assign cmd_ready  = (count != (AW+1)'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_count = count;

    // Head entry feeds the ALU directly; an empty queue presents zeros.
    assign alu_opcode   = empty ? '0 : op_mem[rd_ptr];
    assign alu_operand1 = empty ? '0 : a_mem[rd_ptr];
    assign alu_operand2 = empty ? '0 : b_mem[rd_ptr];

    // Command storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr] <= cmd_opcode;
            a_mem[wr_ptr]  <= cmd_a;
            b_mem[wr_ptr]  <= cmd_b;
        end
    end

    // Queue pointers and occupancy; a push and a pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Response state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RSP_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Pop the head whenever the response slot is free or being drained this cycle.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            RSP_EMPTY: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = RSP_FULL;
                end
            end
            RSP_FULL: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        next_state = RSP_EMPTY;
                    end
                end
            end
            default: next_state = RSP_EMPTY;
        endcase
    end

    // Capture ALU outputs with the next sequence tag on every pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_c      <= 1'b0;
            rsp_z      <= 1'b0;
            rsp_tag    <= '0;
            issue_tag  <= '0;
        end else if (pop) begin
            rsp_result <= alu_result;
            rsp_c      <= alu_flagC;
            rsp_z      <= alu_flagZ;
            rsp_tag    <= issue_tag;
            issue_tag  <= issue_tag + 4'd1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue with an adder stub standing in for the ALU.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_cmd_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_operand1;
    logic [7:0]  alu_operand2;
    logic [15:0] alu_result;
    logic        alu_flagC;
    logic        alu_flagZ;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_c;
    logic        rsp_z;
    logic [3:0]  rsp_tag;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stub ALU.
    assign alu_result = {8'h00, alu_operand1} + {8'h00, alu_operand2};
    assign alu_flagC  = alu_result[8];
    assign alu_flagZ  = (alu_result == 16'h0000);

    alu_cmd_issue #(.DEPTH(4), .OPW(8), .RESW(16)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .alu_opcode(alu_opcode),
        .alu_operand1(alu_operand1),
        .alu_operand2(alu_operand2),
        .alu_result(alu_result),
        .alu_flagC(alu_flagC),
        .alu_flagZ(alu_flagZ),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_c(rsp_c),
        .rsp_z(rsp_z),
        .rsp_tag(rsp_tag),
        .fifo_count(fifo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_opcode = 4'h0;
        cmd_a      = 8'h00;
        cmd_b      = 8'h00;
        rsp_ready  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
    endtask

    logic [7:0]  sa;
    logic [7:0]  sb;
    logic [15:0] exp_res;

    initial begin
        #1;
        do_reset();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_tag", 32'(rsp_tag), 32'd0);
        chk("rst_result", 32'(rsp_result), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // Idle: ALU inputs parked at zero, no response.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_op", 32'(alu_opcode), 32'd0);
            chk("idle_a", 32'(alu_operand1), 32'd0);
            chk("idle_b", 32'(alu_operand2), 32'd0);
            chk("idle_valid", 32'(rsp_valid), 32'd0);
        end

        // Single command, two-edge latency.
        rsp_ready = 1'b1;
        drive(4'h0, 8'hF0, 8'h0A);
        tick();
        cmd_valid = 1'b0;
        chk("single_cnt1", 32'(fifo_count), 32'd1);
        chk("single_nobypass", 32'(rsp_valid), 32'd0);
        chk("single_alu_a", 32'(alu_operand1), 32'hF0);
        tick();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_res", 32'(rsp_result), 32'h00FA);
        chk("single_c", 32'(rsp_c), 32'd0);
        chk("single_z", 32'(rsp_z), 32'd0);
        chk("single_tag", 32'(rsp_tag), 32'd0);
        chk("single_cnt0", 32'(fifo_count), 32'd0);
        tick();
        chk("single_drain", 32'(rsp_valid), 32'd0);
        chk("single_hold", 32'(rsp_result), 32'h00FA);

        // Carry then zero.
        do_reset();
        rsp_ready = 1'b1;
        drive(4'h1, 8'hF0, 8'h20);
        tick();
        drive(4'h2, 8'h00, 8'h00);
        tick();
        cmd_valid = 1'b0;
        chk("carry_res", 32'(rsp_result), 32'h0110);
        chk("carry_c", 32'(rsp_c), 32'd1);
        chk("carry_z", 32'(rsp_z), 32'd0);
        chk("carry_tag", 32'(rsp_tag), 32'd0);
        tick();
        chk("zero_res", 32'(rsp_result), 32'h0000);
        chk("zero_c", 32'(rsp_c), 32'd0);
        chk("zero_z", 32'(rsp_z), 32'd1);
        chk("zero_tag", 32'(rsp_tag), 32'd1);
        tick();
        chk("zero_drain", 32'(rsp_valid), 32'd0);

        // Backpressure: five accepted, sixth refused while full.
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'(i + 1), 8'(8'h10 + i), 8'h01);
            tick();
        end
        chk("bp_full_cnt", 32'(fifo_count), 32'd4);
        chk("bp_full_rdy", 32'(cmd_ready), 32'd0);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        chk("bp_res0", 32'(rsp_result), 32'h0011);
        chk("bp_tag0", 32'(rsp_tag), 32'd0);
        chk("bp_head_op", 32'(alu_opcode), 32'd2);
        drive(4'h6, 8'h15, 8'h01);
        tick();
        chk("bp_refuse_cnt", 32'(fifo_count), 32'd4);
        chk("bp_stable_res", 32'(rsp_result), 32'h0011);
        chk("bp_stable_tag", 32'(rsp_tag), 32'd0);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("bp_drain_valid", 32'(rsp_valid), 32'd1);
            chk("bp_drain_res", 32'(rsp_result), 32'(16'h0011 + 16'(i)));
            chk("bp_drain_tag", 32'(rsp_tag), 32'(i));
        end
        chk("bp_drain_cnt", 32'(fifo_count), 32'd0);
        tick();
        chk("bp_end_valid", 32'(rsp_valid), 32'd0);

        // Reset mid-cycle with queued work and a pending response.
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'h3, 8'(i), 8'h02);
            tick();
        end
        cmd_valid = 1'b0;
        chk("ar_pre_cnt", 32'(fifo_count), 32'd3);
        chk("ar_pre_valid", 32'(rsp_valid), 32'd1);
        chk("ar_pre_tag", 32'(rsp_tag), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(rsp_valid), 32'd0);
        chk("ar_cnt", 32'(fifo_count), 32'd0);
        chk("ar_tag", 32'(rsp_tag), 32'd0);
        chk("ar_alu_op", 32'(alu_opcode), 32'd0);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        drive(4'h4, 8'h07, 8'h08);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("ar_new_valid", 32'(rsp_valid), 32'd1);
        chk("ar_new_res", 32'(rsp_result), 32'h000F);
        chk("ar_new_tag", 32'(rsp_tag), 32'd0);

        // Streaming 20 commands; tag wraps at the 17th response.
        do_reset();
        rsp_ready = 1'b1;
        drive(4'h5, 8'h00, 8'hF0);
        for (int k = 1; k <= 21; k++) begin
            tick();
            chk("st_cnt_le1", 32'(fifo_count <= 3'd1), 32'd1);
            if (k >= 2) begin
                sa      = 8'((k - 2) * 13);
                sb      = 8'hF0;
                exp_res = {8'h00, sa} + {8'h00, sb};
                chk("st_valid", 32'(rsp_valid), 32'd1);
                chk("st_res", 32'(rsp_result), 32'(exp_res));
                chk("st_c", 32'(rsp_c), 32'(exp_res[8]));
                chk("st_tag", 32'(rsp_tag), 32'((k - 2) % 16));
            end
            if (k == 18) begin
                chk("st_wrap", 32'(rsp_tag), 32'd0);
            end
            if (k < 20) begin
                drive(4'h5, 8'(k * 13), 8'hF0);
            end else begin
                cmd_valid = 1'b0;
            end
        end
        chk("st_end_cnt", 32'(fifo_count), 32'd0);
        tick();
        chk("st_end_valid", 32'(rsp_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
